mem_port_sequencer: RTL and testbench

Multi-cycle sequencer that shares one single-ported instruction/data memory between the fetch stage and the load/store path driven by the control unit's MemRead/MemWrite. It arbitrates between the two requesters, drives the memory port, and stalls the PC and pipeline until the selected access completes. It sits between the control unit/datapath and the unified memory.

---
 rtl/mem_port_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mem_port_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sequencer
// Purpose  : Shares one single-ported unified memory between instruction
//            fetch and the load/store path. Data requests win over fetch
//            because they belong to the older instruction in flight. Each
//            access runs IDLE -> DATA/FETCH -> RESP -> IDLE, and the pipeline
//            is stalled until the selected access completes.
// Ports    : clk, reset              clock, asynchronous active-high reset
//            if_req/if_addr          fetch request (held until if_gnt)
//            if_gnt/if_rdata         fetch completion pulse / instruction
//            d_read/d_write/d_addr/  load/store request (held until d_done)
//            d_wdata
//            d_done/d_rdata          data completion pulse / load data
//            mem_en/mem_we/mem_addr/ memory port (latched for the whole
//            mem_wdata               mem_en window)
//            mem_rdata/mem_ack       memory response
//            stall                   freeze PC and pipeline
//            err                     sticky timeout flag
// Options  : MEMSEQ_TIMEOUT_EN -- when defined, an access that waits TIMEOUT
//            mem_en cycles without mem_ack is aborted, returns zero read data
//            and sets err. When undefined, the sequencer waits indefinitely
//            and err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_load;      // current data access is a pure load
    logic   r_err;
    logic   w_timeout;   // abort this cycle instead of waiting further
    logic   w_finish;    // access ends this cycle (ack or abort)
    logic [DATA_W-1:0] w_fill;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("mem_port_sequencer: TIMEOUT must be in 1..255");
        end
    endgenerate

`ifdef MEMSEQ_TIMEOUT_EN
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    logic [7:0] r_wait;  // mem_en cycles already spent without ack

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (r_state == DATA || r_state == FETCH) begin
            if (!mem_ack) begin
                r_wait <= r_wait + 8'd1;
            end
        end else begin
            r_wait <= '0;
        end
    end

    // An ack arriving in the final allowed cycle takes precedence.
    assign w_timeout = ~mem_ack & (r_wait == c_wait_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((r_state == DATA || r_state == FETCH) && w_timeout) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign r_err     = 1'b0;
`endif

    assign err      = r_err;
    assign w_finish = mem_ack | w_timeout;
    // Aborted accesses return zero rather than whatever is on the bus.
    assign w_fill   = mem_ack ? mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_load    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_gnt    <= 1'b0;
            if_rdata  <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
        end else begin
            if_gnt <= 1'b0;
            d_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (d_read || d_write) begin
                        // Read+write together is serviced as a store.
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_we    <= d_write;
                        r_load    <= ~d_write;
                        mem_en    <= 1'b1;
                        r_state   <= DATA;
                    end else if (if_req) begin
                        mem_addr <= if_addr;
                        mem_we   <= 1'b0;
                        mem_en   <= 1'b1;
                        r_state  <= FETCH;
                    end
                end
                DATA: begin
                    if (w_finish) begin
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        d_done  <= 1'b1;
                        r_state <= RESP;
                        if (r_load) begin
                            d_rdata <= w_fill;
                        end
                    end
                end
                FETCH: begin
                    if (w_finish) begin
                        mem_en   <= 1'b0;
                        if_gnt   <= 1'b1;
                        if_rdata <= w_fill;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    // One-cycle gap so a still-held request is not served twice.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall = (d_read | d_write | if_req) & ~(d_done | if_gnt);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_sequencer
// Purpose  : Self-checking bench for mem_port_sequencer. Directed scenarios
//            followed by randomized request mixes, checked against a
//            transaction-level reference model held in the bench.
// Options  : MEMSEQ_TIMEOUT_EN selects the expected no-ack behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_sequencer;

    localparam int c_aw      = 32;
    localparam int c_dw      = 32;
    localparam int c_timeout = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_req;
    logic [c_aw-1:0] if_addr;
    logic            if_gnt;
    logic [c_dw-1:0] if_rdata;
    logic            d_read;
    logic            d_write;
    logic [c_aw-1:0] d_addr;
    logic [c_dw-1:0] d_wdata;
    logic            d_done;
    logic [c_dw-1:0] d_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [c_dw-1:0] mem_wdata;
    logic [c_dw-1:0] mem_rdata;
    logic            mem_ack;
    logic            stall;
    logic            err;

    mem_port_sequencer #(
        .ADDR_W (c_aw),
        .DATA_W (c_dw),
        .TIMEOUT(c_timeout)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rdata (if_rdata),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall    (stall),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: what the registered outputs must hold.
    logic [c_dw-1:0] exp_if_rdata = '0;
    logic [c_dw-1:0] exp_d_rdata  = '0;
    logic            exp_err      = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_req();
        return d_read | d_write | if_req;
    endfunction

    // Entered in an IDLE cycle with at least one request driven. Serves the
    // request the arbitration rule selects, with lat wait cycles before ack.
    task automatic serve_one(input int lat, input logic [c_dw-1:0] rdata, input bit drop);
        bit              is_data, is_wr;
        logic [c_aw-1:0] a;
        logic [c_dw-1:0] wd;
        is_data = d_read | d_write;
        is_wr   = d_write;
        a       = is_data ? d_addr : if_addr;
        wd      = d_wdata;
        mem_ack = $urandom_range(0, 1);
        #1;
        chk("idle_mem_en", mem_en, 1'b0);
        chk("idle_stall", stall, any_req());
        chk("idle_done", {d_done, if_gnt}, 2'b00);
        step();
        if (drop) begin
            if (is_data) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                if_req = 1'b0;
            end
        end
        // Sources change; the port must keep the latched values.
        d_addr  = $urandom;
        d_wdata = $urandom;
        if (!is_data) if_addr = $urandom;
        for (int k = 0; k <= lat; k++) begin
            mem_ack   = (k == lat);
            mem_rdata = (k == lat) ? rdata : $urandom;
            #1;
            chk("acc_mem_en", mem_en, 1'b1);
            chk("acc_mem_we", mem_we, is_wr);
            chk("acc_mem_addr", mem_addr, a);
            if (is_wr) chk("acc_mem_wdata", mem_wdata, wd);
            chk("acc_stall", stall, any_req());
            chk("acc_done", {d_done, if_gnt}, 2'b00);
            step();
        end
        if (is_data && !is_wr) exp_d_rdata = rdata;
        if (!is_data) exp_if_rdata = rdata;
        mem_ack   = $urandom_range(0, 1);
        mem_rdata = $urandom;
        #1;
        chk("resp_d_done", d_done, is_data);
        chk("resp_if_gnt", if_gnt, !is_data);
        chk("resp_mem_en", mem_en, 1'b0);
        chk("resp_d_rdata", d_rdata, exp_d_rdata);
        chk("resp_if_rdata", if_rdata, exp_if_rdata);
        chk("resp_stall", stall, 1'b0);
        chk("resp_err", err, exp_err);
        if (is_data) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            if_req = 1'b0;
        end
        step();
    endtask

    task automatic txn(input bit rd, input bit wr, input bit fq,
                       input logic [c_aw-1:0] da, input logic [c_dw-1:0] wd,
                       input logic [c_aw-1:0] fa, input int lat,
                       input logic [c_dw-1:0] rd0, input logic [c_dw-1:0] rd1,
                       input bit drop);
        int n;
        d_read  = rd;
        d_write = wr;
        if_req  = fq;
        d_addr  = da;
        d_wdata = wd;
        if_addr = fa;
        n = 0;
        while (any_req() && n < 4) begin
            serve_one(lat, (n == 0) ? rd0 : rd1, drop);
            n++;
        end
        chk("txn_drained", any_req(), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        step();
        step();
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_gnt_done", {if_gnt, d_done}, 2'b00);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_stall", stall, 1'b0);
        #2 reset = 1'b0;
        step();

        // Fetch only, ack in the first mem_en cycle.
        txn(0, 0, 1, 32'h0, 32'h0, 32'h40, 0, 32'h2008_0005, 32'h0, 0);
        // Load/fetch collision: data first, then fetch.
        txn(1, 0, 1, 32'h100, 32'h0, 32'h44, 1, 32'hDEAD_BEEF, 32'h1111_2222, 0);
        // Store with 3 mem_en cycles; d_rdata must not move.
        txn(0, 1, 0, 32'h8, 32'h1234, 32'h0, 2, 32'hCAFE_F00D, 32'h0, 0);
        // Read and write together behaves as a store.
        txn(1, 1, 0, 32'hC, 32'h5678, 32'h0, 0, 32'hBAD0_BAD0, 32'h0, 0);

        // Reset in the second mem_en cycle of a fetch.
        if_req  = 1'b1;
        if_addr = 32'h80;
        step();
        mem_ack = 1'b0;
        step();
        reset = 1'b1;
        #1;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        exp_err      = 1'b0;
        chk("mid_rst_mem_en", mem_en, 1'b0);
        chk("mid_rst_if_gnt", if_gnt, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_rdata", {if_rdata, d_rdata}, 64'd0);
        if_req = 1'b0;
        step();
        reset = 1'b0;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        #1;
        chk("late_ack_mem_en", mem_en, 1'b0);
        chk("late_ack_gnt", {if_gnt, if_rdata}, 33'd0);
        txn(0, 0, 1, 32'h0, 32'h0, 32'h84, 1, 32'h0badf00d, 32'h0, 0);

        // Load that never receives an ack.
`ifdef MEMSEQ_TIMEOUT_EN
        d_read  = 1'b1;
        d_addr  = 32'h200;
        mem_ack = 1'b0;
        #1;
        chk("to_idle_mem_en", mem_en, 1'b0);
        step();
        for (int k = 0; k < c_timeout; k++) begin
            chk("to_mem_en", mem_en, 1'b1);
            chk("to_done_early", d_done, 1'b0);
            step();
        end
        exp_d_rdata = '0;
        exp_err     = 1'b1;
        chk("to_d_done", d_done, 1'b1);
        chk("to_d_rdata", d_rdata, exp_d_rdata);
        chk("to_err", err, exp_err);
        d_read = 1'b0;
        step();
`else
        txn(1, 0, 0, 32'h200, 32'h0, 32'h0, 20, 32'h7777_7777, 32'h0, 0);
        chk("noto_err", err, 1'b0);
`endif

        // Randomized request mixes.
        for (int t = 0; t < 60; t++) begin
            int sel;
            int lat;
            sel = $urandom_range(0, 6);
            lat = $urandom_range(0, 3);
            case (sel)
                0: begin
                    mem_ack = $urandom_range(0, 1);
                    #1;
                    chk("rnd_idle_mem_en", mem_en, 1'b0);
                    chk("rnd_idle_stall", stall, 1'b0);
                    step();
                end
                1: txn(0, 0, 1, $urandom, $urandom, $urandom, lat, $urandom, $urandom, $urandom_range(0, 5) == 0);
                2: txn(1, 0, 0, $urandom, $urandom, $urandom, lat, $urandom, $urandom, $urandom_range(0, 5) == 0);
                3: txn(0, 1, 0, $urandom, $urandom, $urandom, lat, $urandom, $urandom, $urandom_range(0, 5) == 0);
                4: txn(1, 1, 0, $urandom, $urandom, $urandom, lat, $urandom, $urandom, 0);
                5: txn(1, 0, 1, $urandom, $urandom, $urandom, lat, $urandom, $urandom, $urandom_range(0, 5) == 0);
                default: txn(0, 1, 1, $urandom, $urandom, $urandom, lat, $urandom, $urandom, 0);
            endcase
            chk("rnd_err", err, exp_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
